sram_bist: RTL
==============

# sram_bist

Parametrised self-test engine for the board SRAM: on a `start` pulse it writes a selectable data pattern over address range 0..`LAST_ADDR`, reads it back, compares, and reports pass/fail, a saturating error count and (optionally) the first failing word. It replaces the button-driven manual read/write harness. It sits between board-level control (switches, debounced buttons, LEDs) and `sram_ctrl`, driving that controller's `mem`/`rw`/`addr`/`data_f2s` request interface.

## Interface
- `AW`, 18: SRAM word-address width.
- `DW`, 16: SRAM data width; must be even and ≥ 8.
- `LAST_ADDR`, 2**AW-1: last address tested, inclusive.
- `ECW`, 16: error-counter width.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a test; honoured only in IDLE.
- `abort`  in  1  stop the test after the current transaction.
- `mode`  in  2  pattern: 0 address, 1 checkerboard, 2 inverted address, 3 seed.
- `seed`  in  DW  constant pattern for mode 3.
- `mem`  out  1  request strobe to `sram_ctrl`.
- `rw`  out  1  1 = read, 0 = write.
- `addr`  out  AW  transaction address.
- `data_f2s`  out  DW  write data.
- `ready`  in  1  controller idle and able to accept a request.
- `data_s2f_r`  in  DW  registered read data, valid when `ready` returns high after a read.
- `busy`  out  1  test in progress.
- `done`  out  1  one-cycle pulse at test end, including abort.
- `pass`  out  1  1 if the last completed, non-aborted test had zero errors.
- `err_count`  out  ECW  mismatches in the last test; saturates at all-ones.
- `first_err_addr`  out  AW  address of the first mismatch.
- `first_err_data`  out  DW  data read at the first mismatch.

## Operation
- Reset values: all outputs 0; `rw` = 1. FSM resets to IDLE.
- States and transitions:
  - IDLE: on `start`, go to WR_REQ. This clears `err_count`, `pass` and the address counter, and latches `mode`/`seed`.
  - WR_REQ: when `ready`=1, assert `mem`=1 and `rw`=0 for exactly one cycle, then go to WR_WAIT.
  - WR_WAIT: ignore `ready` in the first cycle (the controller drops it one cycle late). Then wait for `ready`=1.
    - If `addr` = LAST_ADDR: clear `addr` and go to RD_REQ.
    - Otherwise: increment `addr` and go to WR_REQ.
  - RD_REQ: same as WR_REQ but with `rw`=1; then go to RD_WAIT.
  - RD_WAIT: as WR_WAIT; on `ready`=1 go to CHECK.
  - CHECK: one cycle. Compare `data_s2f_r` with the expected pattern and update the error state.
    - If `addr` = LAST_ADDR: go to FINISH.
    - Otherwise: increment `addr` and go to RD_REQ.
  - FINISH: pulse `done`; set `pass` = (`err_count` == 0); go to IDLE.
- Patterns, where a = `addr` zero-extended or truncated to DW:
  - mode 0: a.
  - mode 1: 0x55.. on even addresses, 0xAA.. on odd addresses.
  - mode 2: ~a.
  - mode 3: `seed`.
- `mem` is never asserted while `ready`=0, and never for two consecutive cycles.
- `data_f2s` is held stable from WR_REQ until `ready` returns.
- `busy` = 1 in every state except IDLE.
- `err_count` increments by 1 per mismatch and holds at all-ones on saturation.
- Abort:
  - `abort` is sampled in any busy state.
  - The current in-flight transaction is always completed: the engine waits for `ready`=1 before leaving.
  - It then goes to FINISH with `pass` forced to 0.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `start` wins, `abort` is ignored.
- Asserting reset mid-test returns to IDLE immediately; the SRAM contents are undefined.
- `LAST_ADDR` = 0: a single write followed by a single read.

## Timing
- `busy` rises in the cycle after `start`.
- Minimum of 2 cycles per write and 3 cycles per read (REQ, WAIT, and CHECK for reads), plus the controller's latency.
- `done` is high for one cycle. `pass` and `err_count` are valid in the same cycle as `done` and are held until the next `start`.
- Outputs `mem`, `rw`, `addr` and `data_f2s` are registered.

## Configuration
- `SRAM_BIST_ERRLOG_EN` defined:
  - `first_err_addr` and `first_err_data` capture the address and read data of the first mismatch after `start`.
  - They are cleared on `start` and held afterwards.
- `SRAM_BIST_ERRLOG_EN` undefined: both outputs are tied to 0 and no capture registers are built.

## Structure
- Package `sram_bist_pkg`: FSM state enum and the mode encodings (`MODE_ADDR`, `MODE_CHK`, `MODE_NADDR`, `MODE_SEED`).
- Sub-module `sram_bist_patgen`: combinational expected-data function of (`addr`, `mode`, `seed`), with parameters AW and DW. It is shared by the write path and the compare path.

## Test plan
- Mode 0, AW=4, LAST_ADDR=15, ideal controller model (ready drops for 2 cycles) -> 16 writes with data = address, then 16 reads; `done` pulses once; `pass`=1; `err_count`=0.
- Mode 1 with the model's bit 3 stuck-at-0 at address 5 -> `err_count`=1, `pass`=0, `first_err_addr`=5, `first_err_data`=0xAAA2 (DW=16, with ERRLOG).
- Mode 3, seed=0x1234, every read returns 0 over 16 addresses, ECW=3 -> `err_count` saturates at 7.
- `abort` asserted during the third write's WAIT -> that write completes, `done` pulses, `pass`=0, no further `mem` pulses.
- `start` during a test, and reset asserted mid-read -> the start has no effect; after reset all outputs are 0 and the FSM is in IDLE; a new test then passes.
- Protocol check across all runs -> `mem` is never high when `ready`=0 and never high on 2 consecutive cycles.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared types for the SRAM self-test engine.
//   state_t  - engine FSM states
//   MODE_*   - pattern select encodings for the 'mode' input
package sram_bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_CHECK,
      S_FINISH
   } state_t;

   localparam logic [1:0] MODE_ADDR  = 2'd0;
   localparam logic [1:0] MODE_CHK   = 2'd1;
   localparam logic [1:0] MODE_NADDR = 2'd2;
   localparam logic [1:0] MODE_SEED  = 2'd3;

endpackage

// File: rtl/sram_bist_patgen.sv
// sram_bist_patgen: combinational expected-data generator.
//   addr [AW] - word address
//   mode [2]  - pattern select (MODE_*)
//   seed [DW] - constant pattern for MODE_SEED
//   pat  [DW] - data written at / expected from 'addr'
module sram_bist_patgen
   import sram_bist_pkg::*;
#(
   parameter int AW = 18,
   parameter int DW = 16
) (
   input  logic [AW-1:0] addr,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] seed,
   output logic [DW-1:0] pat
);

   // address zero-extended or truncated to the data width
   localparam int NB = (AW < DW) ? AW : DW;

   logic [DW-1:0] a;

   always_comb begin
      a         = '0;
      a[NB-1:0] = addr[NB-1:0];
      pat       = seed;
      case (mode)
         MODE_ADDR:  pat = a;
         MODE_CHK:   pat = addr[0] ? {(DW/2){2'b10}} : {(DW/2){2'b01}};
         MODE_NADDR: pat = ~a;
         default:    pat = seed;
      endcase
   end

endmodule

// File: rtl/sram_bist.sv
// sram_bist: SRAM self-test engine driving an sram_ctrl request interface.
// Writes a pattern over 0..LAST_ADDR, reads it back and compares.
//   clk, reset (async, active low)
//   start, abort, mode, seed       - test control
//   mem, rw, addr, data_f2s        - registered request to sram_ctrl
//   ready, data_s2f_r              - controller status / read data
//   busy, done, pass, err_count    - result
//   first_err_addr, first_err_data - first mismatch (only built when
//                                    SRAM_BIST_ERRLOG_EN is defined, else 0)
module sram_bist
   import sram_bist_pkg::*;
#(
   parameter int AW        = 18,
   parameter int DW        = 16,
   parameter int LAST_ADDR = 2**AW-1,
   parameter int ECW       = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   input  logic [DW-1:0] seed,
   output logic          mem,
   output logic          rw,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data_f2s,
   input  logic          ready,
   input  logic [DW-1:0] data_s2f_r,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [ECW-1:0] err_count,
   output logic [AW-1:0] first_err_addr,
   output logic [DW-1:0] first_err_data
);

   localparam logic [AW-1:0] LAST = AW'(LAST_ADDR);

   state_t        state, state_n;
   logic          abort_q;
   logic          wait_1st;   // first WAIT cycle: controller has not dropped ready yet
   logic [1:0]    mode_q;
   logic [DW-1:0] seed_q;
   logic [DW-1:0] pat;
   logic          ab, last, go, mismatch;
   logic          issue_wr, issue_rd, addr_clr, addr_inc, chk;

   sram_bist_patgen #(.AW(AW), .DW(DW)) u_patgen (
      .addr (addr),
      .mode (mode_q),
      .seed (seed_q),
      .pat  (pat)
   );

   assign busy     = (state != S_IDLE);
   assign ab       = abort_q | abort;
   assign last     = (addr == LAST);
   assign go       = start & (state == S_IDLE);
   assign mismatch = (data_s2f_r != pat);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      issue_wr = 1'b0;
      issue_rd = 1'b0;
      addr_clr = 1'b0;
      addr_inc = 1'b0;
      chk      = 1'b0;
      case (state)
         S_IDLE: if (start) state_n = S_WR_REQ;
         S_WR_REQ: begin
            if (ab) state_n = S_FINISH;
            else if (ready) begin
               issue_wr = 1'b1;
               state_n  = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (!wait_1st && ready) begin
               if (ab) state_n = S_FINISH;
               else if (last) begin
                  addr_clr = 1'b1;
                  state_n  = S_RD_REQ;
               end else begin
                  addr_inc = 1'b1;
                  state_n  = S_WR_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (ab) state_n = S_FINISH;
            else if (ready) begin
               issue_rd = 1'b1;
               state_n  = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (!wait_1st && ready) state_n = ab ? S_FINISH : S_CHECK;
         end
         S_CHECK: begin
            chk = 1'b1;
            if (ab || last) state_n = S_FINISH;
            else begin
               addr_inc = 1'b1;
               state_n  = S_RD_REQ;
            end
         end
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem       <= 1'b0;
         rw        <= 1'b1;
         addr      <= '0;
         data_f2s  <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         abort_q   <= 1'b0;
         wait_1st  <= 1'b0;
         mode_q    <= MODE_ADDR;
         seed_q    <= '0;
      end else begin
         mem      <= issue_wr | issue_rd;
         wait_1st <= issue_wr | issue_rd;
         // done/pass land together one cycle after FINISH
         done     <= (state == S_FINISH);
         if (go) begin
            addr      <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            abort_q   <= 1'b0;
            mode_q    <= mode;
            seed_q    <= seed;
         end else begin
            if (busy && abort) abort_q <= 1'b1;
            if (addr_clr)      addr <= '0;
            else if (addr_inc) addr <= addr + AW'(1);
            if (chk && mismatch && !(&err_count)) err_count <= err_count + ECW'(1);
            if (state == S_FINISH) pass <= !ab && (err_count == '0);
         end
         if (issue_wr) begin
            rw       <= 1'b0;
            data_f2s <= pat;
         end
         if (issue_rd) rw <= 1'b1;
      end
   end

`ifdef SRAM_BIST_ERRLOG_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (go) begin
         first_err_addr <= '0;
         first_err_data <= '0;
      end else if (chk && mismatch && (err_count == '0)) begin
         // zero count means no earlier mismatch since start
         first_err_addr <= addr;
         first_err_data <= data_s2f_r;
      end
   end
`else
   assign first_err_addr = '0;
   assign first_err_data = '0;
`endif

endmodule
